ir_a2d_sequencer: RTL and testbench

Upstream SPI master and sweep controller for the MazeRunner IR line sensors. On a `start` pulse it enables the IR emitters and waits a settle time. It then runs nine pipelined 16-bit transactions against the ADC128S-style A2D, which carries 8 channels. It emits one (channel, 12-bit reading) strobe per channel, in channel order 0..7, and feeds the line-position logic.

---
 rtl/ir_a2d_sequencer.sv | 137 +++++++++++++
 tb/tb_ir_a2d_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ir_a2d_sequencer.sv
// SPI master and sweep sequencer for the IR line-sensor A2D. Each sweep powers the
// emitters, waits for them to settle, then reads channels 0..7 through nine pipelined frames.
module ir_a2d_sequencer #(
  parameter int SETTLE_CYCLES = 1024,
  parameter int GAP_CYCLES    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        IR_EN,
  output logic [2:0]  rd_chnl,
  output logic [11:0] rd_data,
  output logic        rd_vld,
  output logic        busy,
  output logic        done
);

  localparam int MAXC   = (SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES;
  localparam int CW_RAW = $clog2(MAXC + 1);
  localparam int CW     = (CW_RAW > 10) ? CW_RAW : 10;

  typedef enum logic [2:0] {IDLE, SETTLE, XFER, GAP, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     t_q, t_d;
  logic [3:0]     t_next;
  logic [15:0]    tx_q, tx_d;
  logic [11:0]    rx_q, rx_d;
  logic [2:0]     rd_chnl_q, rd_chnl_d;
  logic [11:0]    rd_data_q, rd_data_d;
  logic           rd_vld_q, rd_vld_d;
  logic           in_xfer, frame_end, sclk_low, sclk_rise, mosi_adv;

  // Within a frame the low five counter bits act as the clk/32 SCLK divider:
  // 16-clock front porch, 16 low/high bit periods, then a 16-clock back porch.
  always_comb begin
    in_xfer   = (state_q == XFER);
    frame_end = in_xfer && (cnt_q == CW'(543));
    sclk_low  = in_xfer && cnt_q[4] && (cnt_q < CW'(528));
    sclk_rise = in_xfer && (cnt_q[4:0] == 5'd0) && (cnt_q >= CW'(32)) && (cnt_q <= CW'(512));
    mosi_adv  = in_xfer && (cnt_q[4:0] == 5'd15) && (cnt_q >= CW'(47)) && (cnt_q <= CW'(511));
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    t_d       = t_q;
    t_next    = t_q + 4'd1;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rd_chnl_d = rd_chnl_q;
    rd_data_d = rd_data_q;
    rd_vld_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          state_d = XFER;
          cnt_d   = '0;
          t_d     = 4'd0;
          tx_d    = 16'h0000;
        end
      end
      XFER: begin
        if (sclk_rise) rx_d = {rx_q[10:0], MISO};
        if (mosi_adv)  tx_d = {tx_q[14:0], 1'b0};
        if (frame_end) begin
          cnt_d = '0;
          // Frame 0 returns stale data from before the sweep, so it never strobes.
          if (t_q != 4'd0) begin
            rd_vld_d  = 1'b1;
            rd_chnl_d = t_q[2:0] - 3'd1;
            rd_data_d = rx_q;
          end
          state_d = (t_q == 4'd8) ? DONE : GAP;
        end
      end
      GAP: begin
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          state_d = XFER;
          cnt_d   = '0;
          t_d     = t_next;
          tx_d    = {2'b00, t_next[2:0], 11'h000};
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      t_q       <= 4'd0;
      tx_q      <= 16'h0000;
      rx_q      <= 12'h000;
      rd_chnl_q <= 3'd0;
      rd_data_q <= 12'h000;
      rd_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      t_q       <= t_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rd_chnl_q <= rd_chnl_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  assign SS_n    = ~in_xfer;
  assign SCLK    = ~sclk_low;
  assign MOSI    = in_xfer & tx_q[15];
  assign IR_EN   = (state_q == SETTLE) || (state_q == XFER) || (state_q == GAP);
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign rd_chnl = rd_chnl_q;
  assign rd_data = rd_data_q;
  assign rd_vld  = rd_vld_q;

endmodule

// File: tb/tb_ir_a2d_sequencer.sv
// Scoreboard bench for ir_a2d_sequencer: an A2D model answers frames pipelined,
// a monitor pops expected readings/done times, and a protocol checker watches each frame.
module tb_ir_a2d_sequencer;

  localparam int SETTLE  = 1024;
  localparam int GAP     = 32;
  localparam int FRAME   = 544;
  localparam int LATENCY = 1 + SETTLE + 9 * FRAME + 8 * GAP;

  typedef struct packed {
    logic [2:0]  ch;
    logic [11:0] data;
  } rdExp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        MISO;
  logic        SS_n, SCLK, MOSI, IR_EN, rd_vld, busy, done;
  logic [2:0]  rd_chnl;
  logic [11:0] rd_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int strobeCount = 0;
  int doneCount = 0;
  int idleViol = 0;

  rdExp_t      expQ[$];
  int          doneQ[$];
  rdExp_t      popped;
  logic [11:0] adcVal [8];

  // A2D model and protocol checker state
  int          frameIdx = 0;
  int          irCnt = 0;
  int          rises = 0;
  int          falls = 0;
  int          stableViol = 0;
  int          expCh;
  logic [2:0]  prevCh = 3'd0;
  logic [15:0] outWord = 16'h0;
  logic [15:0] cmdSr = 16'h0;
  logic        ssPrev = 1'b1, sclkPrev = 1'b1, mosiPrev = 1'b0;

  ir_a2d_sequencer #(.SETTLE_CYCLES(SETTLE), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .start(start),
    .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .IR_EN(IR_EN), .rd_chnl(rd_chnl), .rd_data(rd_data),
    .rd_vld(rd_vld), .busy(busy), .done(done)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a reading or signals done.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_vld) begin
        strobeCount++;
        if (expQ.size() == 0) checkOutput("unexpected_rd_vld", 32'd1, 32'd0);
        else begin
          popped = expQ.pop_front();
          checkOutput("rd_chnl", 32'(rd_chnl), 32'(popped.ch));
          checkOutput("rd_data", 32'(rd_data), 32'(popped.data));
        end
      end
      if (done) begin
        doneCount++;
        checkOutput("done_ir_en", 32'(IR_EN), 32'd0);
        if (doneQ.size() == 0) checkOutput("unexpected_done", 32'd1, 32'd0);
        else checkOutput("done_latency", 32'(cyc), 32'(doneQ.pop_front()));
      end
    end
  end

  // A2D model: answers each frame with the channel commanded in the previous frame,
  // shifting MISO on SCLK falls, and checks the SPI framing as it goes.
  always @(negedge clk) begin
    if (rst) begin
      frameIdx = 0;
      prevCh   = 3'd0;
      irCnt    = 0;
      ssPrev   = 1'b1;
      sclkPrev = 1'b1;
      mosiPrev = 1'b0;
      MISO     = 1'b0;
    end else begin
      if (SS_n && (!SCLK || MOSI)) idleViol++;
      if (IR_EN && SS_n && frameIdx == 0) irCnt++;
      else if (!IR_EN) irCnt = 0;
      if (ssPrev && !SS_n) begin
        if (frameIdx == 0) checkOutput("settle_ir_en_cycles", 32'(irCnt), 32'(SETTLE));
        outWord    = {4'hA, adcVal[prevCh]};
        MISO       = outWord[15];
        rises      = 0;
        falls      = 0;
        cmdSr      = 16'h0;
        stableViol = 0;
      end else if (!SS_n) begin
        if (sclkPrev && !SCLK) begin
          falls++;
          if (falls > 1) begin
            outWord = {outWord[14:0], 1'b0};
            MISO    = outWord[15];
          end
        end
        if (!sclkPrev && SCLK) begin
          rises++;
          cmdSr = {cmdSr[14:0], MOSI};
          if (MOSI !== mosiPrev) stableViol++;
        end
      end else if (!ssPrev && SS_n) begin
        expCh = (frameIdx < 8) ? frameIdx : 0;
        checkOutput("frame_rise_count", 32'(rises), 32'd16);
        checkOutput("frame_cmd", 32'(cmdSr), 32'(expCh << 11));
        checkOutput("mosi_stable", 32'(stableViol), 32'd0);
        prevCh = cmdSr[13:11];
        frameIdx++;
        MISO = 1'b0;
      end
      if (done) frameIdx = 0;
      ssPrev   = SS_n;
      sclkPrev = SCLK;
      mosiPrev = MOSI;
    end
  end

  task automatic applyStimulus(input logic [7:0][11:0] vals, input int extraStarts, input bit abortInFrame4);
    int doneBefore;
    int strobesBefore;
    int nExp;
    doneBefore    = doneCount;
    strobesBefore = strobeCount;
    nExp          = abortInFrame4 ? 3 : 8;
    for (int i = 0; i < 8; i++) adcVal[i] = vals[i];
    for (int i = 0; i < nExp; i++) expQ.push_back('{ch: 3'(i), data: vals[i]});
    @(negedge clk);
    start = 1'b1;
    if (!abortInFrame4) doneQ.push_back(cyc + LATENCY);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < extraStarts; k++) begin
      repeat (500) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    if (abortInFrame4) begin
      for (int n = 0; n < 2 * LATENCY && !(frameIdx == 4 && !SS_n); n++) @(negedge clk);
      checkOutput("abort_reached_frame4", 32'(frameIdx), 32'd4);
      repeat (200) @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("abort_ss_n", 32'(SS_n), 32'd1);
      checkOutput("abort_ir_en", 32'(IR_EN), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_sclk", 32'(SCLK), 32'd1);
      checkOutput("abort_rd_data", 32'(rd_data), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_queue_drained", 32'(expQ.size()), 32'd0);
      repeat (20) @(negedge clk);
      checkOutput("abort_no_done", 32'(doneCount), 32'(doneBefore));
    end else begin
      for (int n = 0; n < LATENCY + 200 && doneCount == doneBefore; n++) @(negedge clk);
      checkOutput("sweep_done_seen", 32'(doneCount), 32'(doneBefore + 1));
      repeat (300) @(negedge clk);
      checkOutput("sweep_idle_after", 32'(busy), 32'd0);
      checkOutput("sweep_single_done", 32'(doneCount), 32'(doneBefore + 1));
      checkOutput("sweep_strobes", 32'(strobeCount - strobesBefore), 32'd8);
      checkOutput("sweep_queue_drained", 32'(expQ.size()), 32'd0);
      checkOutput("idle_protocol", 32'(idleViol), 32'd0);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) adcVal[i] = 12'hFFF;
    repeat (3) @(negedge clk);
    checkOutput("reset_ss_n", 32'(SS_n), 32'd1);
    checkOutput("reset_sclk", 32'(SCLK), 32'd1);
    checkOutput("reset_mosi", 32'(MOSI), 32'd0);
    checkOutput("reset_ir_en", 32'(IR_EN), 32'd0);
    checkOutput("reset_rd_chnl", 32'(rd_chnl), 32'd0);
    checkOutput("reset_rd_data", 32'(rd_data), 32'd0);
    checkOutput("reset_rd_vld", 32'(rd_vld), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Channel 7 is the leftmost entry of each vector.
    applyStimulus({12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}, 0, 1'b1);
    applyStimulus({12'hFFF, 12'hFFF, 12'hFFF, 12'hF00, 12'hFFF, 12'hFFF, 12'hFFF, 12'hF00}, 0, 1'b0);
    applyStimulus({12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}, 0, 1'b0);
    applyStimulus({12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hE00}, 0, 1'b0);
    applyStimulus({12'h7FF, 12'h800, 12'h001, 12'hDEF, 12'hABC, 12'h789, 12'h456, 12'h123}, 3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(90000 * 20);
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
